usb_line_state_detector: RTL
============================

Name: usb_line_state_detector

Overview:
- Upstream stage of the host-controller receive status monitor. Produces its connect-state and resume-detected inputs.
- Synchronises raw D+/D- line state and debounces it.
- Decides DISCONNECTED / low-speed / full-speed attachment.
- Detects a downstream resume (K signalling) while the port is suspended.

Parameters:
- CONNECT_DEBOUNCE, 120: cycles the idle J state must be stable before a connect is declared (2.5 us at 48 MHz).
- DISCONNECT_DEBOUNCE, 120: cycles SE0 must be stable before a disconnect is declared.
- RESUME_DEBOUNCE, 48: cycles K must be stable while suspended before resume is flagged.
- CNT_W, 16: stable-counter width. Must satisfy 2^CNT_W-1 >= max(all thresholds).

Ports:
- clk  input  1  system clock, 48 MHz. The only clock.
- rst  input  1  synchronous, active-high reset.
- lineStateIn  input  2  raw async line state; bit1=D+, bit0=D-.
- suspendIn  input  1  host port is in suspend; enables resume detection.
- connectStateOut  output  2  00 disconnected, 01 low-speed, 10 full-speed; 11 never driven.
- resumeDetectedOut  output  1  level, resume K seen while suspended.
- lineStateOut  output  2  synchronised line state (after 2 flops), for downstream use.

Behaviour:
- Reset (rst=1 at posedge): both sync flops=00, lineStateOut=00, stable counter=0, FSM=DISCONNECTED, connectStateOut=00, resumeDetectedOut=0. Reset applies mid-operation identically, including mid-debounce.
- Synchroniser: two flops. lineStateOut follows lineStateIn with 2-cycle latency. All decisions use the second-flop value S.
- Stable counter:
  - Cleared to 0 on any cycle where S differs from its previous-cycle value.
  - Otherwise incremented, saturating at 2^CNT_W-1; never wraps.
  - If S=11 (SE1, illegal), the counter is held at 0 every cycle S=11. No transition and no resume.
- "Stable for N" means counter == N-1 on the current cycle. The resulting output change is registered, so it is visible on the next cycle. A line state first appearing on S at cycle t therefore changes the output at cycle t+N.
- FSM states:
  - DISCONNECTED (out 00):
    - S=10 stable CONNECT_DEBOUNCE → FULL_SPEED.
    - S=01 stable CONNECT_DEBOUNCE → LOW_SPEED.
  - FULL_SPEED (out 10): S=00 stable DISCONNECT_DEBOUNCE → DISCONNECTED.
  - LOW_SPEED (out 01): S=00 stable DISCONNECT_DEBOUNCE → DISCONNECTED.
  - A J/K change between connected states never changes speed. Speed is only re-evaluated from DISCONNECTED.
- Resume:
  - K is 01 in FULL_SPEED and 10 in LOW_SPEED.
  - Condition to set resumeDetectedOut=1: suspendIn=1, FSM connected, and S==K stable RESUME_DEBOUNCE.
  - Once set it stays 1 while suspendIn=1, even after K ends.
  - Cleared on the cycle after suspendIn=0, or on the same cycle the FSM enters DISCONNECTED.
  - K present when suspendIn rises: the counter already running counts. Resume fires when the counter reaches RESUME_DEBOUNCE-1 with suspendIn=1.
  - Disconnect and resume conditions cannot coincide, because they require different S values.
- Short glitches (shorter than the threshold) produce no output change. The counter restarts on return to the previous state.

Test Plan:
- Use CONNECT_DEBOUNCE=8, DISCONNECT_DEBOUNCE=8, RESUME_DEBOUNCE=4.
- FS connect: after reset, lineStateIn=10 held from cycle 0. Required: lineStateOut=10 at cycle 2; connectStateOut=10 at cycle 10 and 00 before it; resumeDetectedOut=0 throughout.
- LS connect with glitch: drive lineStateIn=01 for 5 cycles, then 00 for 1 cycle, then 01 held. Required: connectStateOut stays 00 through the glitch, then =01 exactly 8 cycles after S returns to 01.
- Disconnect: FS connected; drive SE0 for 7 cycles, back to J, then SE0 held. Required: no disconnect on the first pulse; connectStateOut=00 exactly 8 cycles after S=00 on the second.
- Resume: FS connected, suspendIn=1, lineStateIn=01 held. Required: resumeDetectedOut=1 4 cycles after S=01, held after J returns; cleared the cycle after suspendIn=0.
- SE1 and no-suspend: lineStateIn=11 held 20 cycles while DISCONNECTED → connectStateOut stays 00. K held 10 cycles with suspendIn=0 while FS → resumeDetectedOut stays 0.
- Reset mid-operation: assert rst for 1 cycle while FS with resumeDetectedOut=1 → next cycle all outputs 00/0. With lineStateIn=10 still held, the FS connect recurs 10 cycles after rst deasserts.

Source files
------------

// File: rtl/usb_line_state_detector.sv
// USB line-state front end: synchronises D+/D-, debounces it, and tracks attach speed
// plus resume K signalling while the port is suspended.
//
// state        | meaning
// DISCONNECTED | no device; waiting for stable J to learn speed
// LOW_SPEED    | device attached with J = 01
// FULL_SPEED   | device attached with J = 10
module usb_line_state_detector #(
  parameter int CONNECT_DEBOUNCE    = 120,
  parameter int DISCONNECT_DEBOUNCE = 120,
  parameter int RESUME_DEBOUNCE     = 48,
  parameter int CNT_W               = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] lineStateIn,
  input  logic       suspendIn,
  output logic [1:0] connectStateOut,
  output logic       resumeDetectedOut,
  output logic [1:0] lineStateOut
);

  localparam logic [CNT_W-1:0] CONNECT_TC    = CNT_W'(CONNECT_DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] DISCONNECT_TC = CNT_W'(DISCONNECT_DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] RESUME_TC     = CNT_W'(RESUME_DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX       = '1;

  typedef enum logic [1:0] {
    DISCONNECTED = 2'b00,
    LOW_SPEED    = 2'b01,
    FULL_SPEED   = 2'b10
  } state_t;

  state_t           state;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [CNT_W-1:0] stable_cnt;
  logic [1:0]       k_state;
  logic             connect_hit;
  logic             disconnect_hit;
  logic             resume_hit;

  assign lineStateOut = sync2;

  // The counter looks one flop ahead (sync1 vs sync2) so that it already reads 0
  // on the first cycle a new value sits in sync2; SE1 pins it at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 2'b00;
      sync2      <= 2'b00;
      stable_cnt <= '0;
    end else begin
      sync1 <= lineStateIn;
      sync2 <= sync1;
      if ((sync1 != sync2) || (sync1 == 2'b11)) begin
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

  // SE1 never matches any of the required line values, so no extra gating is needed.
  assign k_state        = (state == FULL_SPEED) ? 2'b01 : 2'b10;
  assign connect_hit    = (stable_cnt == CONNECT_TC);
  assign disconnect_hit = (stable_cnt == DISCONNECT_TC) && (sync2 == 2'b00);
  assign resume_hit     = (stable_cnt == RESUME_TC) && (sync2 == k_state);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= DISCONNECTED;
      connectStateOut   <= 2'b00;
      resumeDetectedOut <= 1'b0;
    end else begin
      case (state)
        DISCONNECTED: begin
          resumeDetectedOut <= 1'b0;
          if (connect_hit && (sync2 == 2'b10)) begin
            state           <= FULL_SPEED;
            connectStateOut <= 2'b10;
          end else if (connect_hit && (sync2 == 2'b01)) begin
            state           <= LOW_SPEED;
            connectStateOut <= 2'b01;
          end
        end
        FULL_SPEED, LOW_SPEED: begin
          if (disconnect_hit) begin
            state             <= DISCONNECTED;
            connectStateOut   <= 2'b00;
            resumeDetectedOut <= 1'b0;
          end else if (!suspendIn) begin
            resumeDetectedOut <= 1'b0;
          end else if (resume_hit) begin
            resumeDetectedOut <= 1'b1;
          end
        end
        default: begin
          state             <= DISCONNECTED;
          connectStateOut   <= 2'b00;
          resumeDetectedOut <= 1'b0;
        end
      endcase
    end
  end

endmodule
